// File: rtl/sram_responder_pkg.sv
// Shared constants and state encoding for the SRAM pin-level responder.
package sram_responder_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned BYTE_W      = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdWait = 2'd1,
    StRdDrive = 2'd2,
    StWrPend = 2'd3
  } state_e;

endpackage

// File: rtl/sram_responder_if.sv
// Control and address pins of the asynchronous SRAM. The bidirectional data pin is
// kept as a plain port on the responder so tri-state resolution stays at a module
// boundary.
interface sram_responder_if;
  import sram_responder_pkg::*;

  logic [SRAM_ADDR_W-1:0] SRAM_ADDR;
  logic                   SRAM_UB_N;
  logic                   SRAM_LB_N;
  logic                   SRAM_WE_N;
  logic                   SRAM_CE_N;
  logic                   SRAM_OE_N;

  // Memory controller side.
  modport master (
    output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );

  // Device (responder) side.
  modport slave (
    input SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );

endinterface

// File: rtl/sram_byte_array.sv
// 2^ADDR_BITS x 16 storage with per-byte write enables and an asynchronous read port.
// No reset: contents survive responder resets, like the real device.
module sram_byte_array
  import sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                   clk,
  input  logic                   we_hi,
  input  logic                   we_lo,
  input  logic [ADDR_BITS-1:0]   waddr,
  input  logic [SRAM_DATA_W-1:0] wdata,
  input  logic [ADDR_BITS-1:0]   raddr,
  output logic [SRAM_DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  logic [SRAM_DATA_W-1:0] mem [Depth];

  // Byte-lane writes.
  always_ff @(posedge clk) begin
    if (we_hi) mem[waddr][SRAM_DATA_W-1:BYTE_W] <= wdata[SRAM_DATA_W-1:BYTE_W];
    if (we_lo) mem[waddr][BYTE_W-1:0]           <= wdata[BYTE_W-1:0];
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sram_responder.sv
// Clocked stand-in for an external 16-bit asynchronous SRAM. Reads are answered after
// READ_LATENCY edges, writes commit on release of WE_N/CE_N. Debug counters saturate.
// READ_LATENCY must lie in 1..15.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 10,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_responder_if.slave        bus,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count,
  output logic                   proto_err,
  output logic                   busy
);

  localparam logic [3:0] CntReload = 4'(READ_LATENCY - 1);

  logic rd_req;
  logic wr_act;
  logic addr_chg;
  logic drive_en;
  logic rd_done;
  logic wr_commit;

  state_e                 state_q, state_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [SRAM_DATA_W-1:0] data_q, data_d;
  logic                   ub_n_q, ub_n_d;
  logic                   lb_n_q, lb_n_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [15:0]            rd_count_q, rd_count_d;
  logic [15:0]            wr_count_q, wr_count_d;
  logic                   proto_err_q, proto_err_d;
  logic [SRAM_DATA_W-1:0] rdata;

  // WE_N low dominates OE_N, so a write request never also counts as a read.
  assign rd_req   = !bus.SRAM_CE_N && !bus.SRAM_OE_N && bus.SRAM_WE_N;
  assign wr_act   = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
  assign addr_chg = (bus.SRAM_ADDR != addr_q);

  // Next-state, latches and counters.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    ub_n_d      = ub_n_q;
    lb_n_d      = lb_n_q;
    cnt_d       = cnt_q;
    rd_done     = 1'b0;
    wr_commit   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_act) begin
          state_d = StWrPend;
          addr_d  = bus.SRAM_ADDR;
          data_d  = SRAM_DQ;
          ub_n_d  = bus.SRAM_UB_N;
          lb_n_d  = bus.SRAM_LB_N;
        end else if (rd_req) begin
          state_d = StRdWait;
          addr_d  = bus.SRAM_ADDR;
          cnt_d   = CntReload;
        end
      end
      StRdWait: begin
        if (!rd_req) begin
          state_d = StIdle;
        end else if (addr_chg) begin
          addr_d = bus.SRAM_ADDR;
          cnt_d  = CntReload;
        end else if (cnt_q == 4'd0) begin
          state_d = StRdDrive;
          rd_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRdDrive: begin
        // A write always wins so its data phase is latched without a lost cycle.
        if (wr_act) begin
          state_d = StWrPend;
          addr_d  = bus.SRAM_ADDR;
          data_d  = SRAM_DQ;
          ub_n_d  = bus.SRAM_UB_N;
          lb_n_d  = bus.SRAM_LB_N;
        end else if (!rd_req) begin
          state_d = StIdle;
        end else if (addr_chg) begin
          state_d = StRdWait;
          addr_d  = bus.SRAM_ADDR;
          cnt_d   = CntReload;
        end
      end
      StWrPend: begin
        if (wr_act) begin
          addr_d = bus.SRAM_ADDR;
          data_d = SRAM_DQ;
          ub_n_d = bus.SRAM_UB_N;
          lb_n_d = bus.SRAM_LB_N;
        end else begin
          wr_commit = !(ub_n_q && lb_n_q);
          if (rd_req) begin
            state_d = StRdWait;
            addr_d  = bus.SRAM_ADDR;
            cnt_d   = CntReload;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    rd_count_d  = (rd_done && rd_count_q != 16'hFFFF) ? rd_count_q + 16'd1 : rd_count_q;
    wr_count_d  = (wr_commit && wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;
    proto_err_d = proto_err_q
                  | (!bus.SRAM_CE_N && !bus.SRAM_WE_N && !bus.SRAM_OE_N);
  end

  // State and debug registers; array contents are deliberately not reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      data_q      <= '0;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      cnt_q       <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
      cnt_q       <= cnt_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      proto_err_q <= proto_err_d;
    end
  end

  sram_byte_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk  (clk),
    .we_hi(wr_commit && !ub_n_q),
    .we_lo(wr_commit && !lb_n_q),
    .waddr(addr_q[ADDR_BITS-1:0]),
    .wdata(data_q),
    .raddr(addr_q[ADDR_BITS-1:0]),
    .rdata(rdata)
  );

  // Combinational enable: the bus lets go in the same cycle the request drops,
  // and reset releases it asynchronously through state_q.
  assign drive_en = (state_q == StRdDrive) && rd_req;

  assign SRAM_DQ[SRAM_DATA_W-1:BYTE_W] = (drive_en && !bus.SRAM_UB_N)
                                         ? rdata[SRAM_DATA_W-1:BYTE_W] : {BYTE_W{1'bz}};
  assign SRAM_DQ[BYTE_W-1:0]           = (drive_en && !bus.SRAM_LB_N)
                                         ? rdata[BYTE_W-1:0] : {BYTE_W{1'bz}};

  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign proto_err = proto_err_q;
  assign busy      = (state_q == StRdWait) || (state_q == StWrPend);

endmodule

// File: tb/tb_sram_responder.sv
// Directed and randomized checks of sram_responder against a word-array model.
// A pull-up on the data bus makes a released lane read as 8'hFF.
module tb_sram_responder;

  localparam int unsigned ADDR_BITS    = 10;
  localparam int unsigned READ_LATENCY = 2;
  localparam int unsigned DEPTH        = 1 << ADDR_BITS;

  logic        clk = 1'b0;
  logic        rst;
  wire  [15:0] sram_dq;
  logic [15:0] tb_dq;
  logic        tb_dq_en;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic        proto_err;
  logic        busy;

  sram_responder_if bus ();

  assign sram_dq = tb_dq_en ? tb_dq : 16'hzzzz;

  for (genvar i = 0; i < 16; i++) begin : g_pull
    pullup pu (sram_dq[i]);
  end

  always #5 clk = ~clk;

  sram_responder #(
    .ADDR_BITS   (ADDR_BITS),
    .READ_LATENCY(READ_LATENCY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .SRAM_DQ  (sram_dq),
    .rd_count (rd_count),
    .wr_count (wr_count),
    .proto_err(proto_err),
    .busy     (busy)
  );

  // Reference state.
  logic [15:0] model_mem [DEPTH];
  logic [15:0] exp_rd;
  logic [15:0] exp_wr;
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [17:0] pool [8];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [15:0] model_read(input logic [17:0] a, input logic ub_n,
                                             input logic lb_n);
    logic [15:0] w;
    w = model_mem[a[ADDR_BITS-1:0]];
    return {ub_n ? 8'hFF : w[15:8], lb_n ? 8'hFF : w[7:0]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_pins();
    bus.SRAM_CE_N = 1'b1;
    bus.SRAM_OE_N = 1'b1;
    bus.SRAM_WE_N = 1'b1;
    bus.SRAM_UB_N = 1'b0;
    bus.SRAM_LB_N = 1'b0;
    tb_dq_en      = 1'b0;
  endtask

  task automatic set_write(input logic [17:0] a, input logic [15:0] d, input logic ub_n,
                           input logic lb_n);
    bus.SRAM_ADDR = a;
    bus.SRAM_UB_N = ub_n;
    bus.SRAM_LB_N = lb_n;
    bus.SRAM_CE_N = 1'b0;
    bus.SRAM_WE_N = 1'b0;
    bus.SRAM_OE_N = 1'b1;
    tb_dq         = d;
    tb_dq_en      = 1'b1;
  endtask

  task automatic model_write(input logic [17:0] a, input logic [15:0] d, input logic ub_n,
                             input logic lb_n);
    if (!ub_n) model_mem[a[ADDR_BITS-1:0]][15:8] = d[15:8];
    if (!lb_n) model_mem[a[ADDR_BITS-1:0]][7:0]  = d[7:0];
    if (!ub_n || !lb_n) exp_wr = sat_inc(exp_wr);
  endtask

  // Write held for 'hold' cycles, then released; commit happens on the next edge.
  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic ub_n,
                          input logic lb_n, input int unsigned hold);
    @(negedge clk);
    set_write(a, d, ub_n, lb_n);
    repeat (hold) @(negedge clk);
    check("wr_busy", 16'(busy), 16'd1);
    bus.SRAM_CE_N = 1'b1;
    bus.SRAM_WE_N = 1'b1;
    tb_dq_en      = 1'b0;
    model_write(a, d, ub_n, lb_n);
  endtask

  // Read pins are already set at a negedge; the next edge samples the request.
  task automatic read_tail(input logic [17:0] a, input logic ub_n, input logic lb_n,
                           input string tag);
    repeat (READ_LATENCY) @(negedge clk);
    check({tag, "_early"}, sram_dq, 16'hFFFF);
    check({tag, "_wait_busy"}, 16'(busy), 16'd1);
    check({tag, "_wr_count"}, wr_count, exp_wr);
    @(negedge clk);
    exp_rd = sat_inc(exp_rd);
    check({tag, "_data"}, sram_dq, model_read(a, ub_n, lb_n));
    check({tag, "_rd_count"}, rd_count, exp_rd);
    check({tag, "_drive_busy"}, 16'(busy), 16'd0);
    bus.SRAM_CE_N = 1'b1;
    bus.SRAM_OE_N = 1'b1;
    #1;
    check({tag, "_release"}, sram_dq, 16'hFFFF);
  endtask

  task automatic set_read(input logic [17:0] a, input logic ub_n, input logic lb_n);
    bus.SRAM_ADDR = a;
    bus.SRAM_UB_N = ub_n;
    bus.SRAM_LB_N = lb_n;
    bus.SRAM_CE_N = 1'b0;
    bus.SRAM_OE_N = 1'b0;
    bus.SRAM_WE_N = 1'b1;
  endtask

  task automatic do_read(input logic [17:0] a, input logic ub_n, input logic lb_n,
                         input string tag);
    @(negedge clk);
    set_read(a, ub_n, lb_n);
    read_tail(a, ub_n, lb_n, tag);
  endtask

  initial begin
    logic [17:0] a;
    logic [15:0] d;

    rst    = 1'b0;
    tb_dq  = 16'h0000;
    bus.SRAM_ADDR = '0;
    idle_pins();
    exp_rd = 16'd0;
    exp_wr = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_rd_count", rd_count, 16'd0);
    check("rst_wr_count", wr_count, 16'd0);
    check("rst_proto_err", 16'(proto_err), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_dq", sram_dq, 16'hFFFF);
    rst = 1'b1;

    // Write then read.
    do_write(18'h00005, 16'hBEEF, 1'b0, 1'b0, 2);
    do_read(18'h00005, 1'b0, 1'b0, "wr_rd");

    // Byte lanes.
    do_write(18'h0000A, 16'h1234, 1'b0, 1'b0, 1);
    do_write(18'h0000A, 16'hAB00, 1'b0, 1'b1, 2);
    do_read(18'h0000A, 1'b0, 1'b0, "lane_merge");
    do_read(18'h0000A, 1'b1, 1'b0, "lane_ub_off");

    // Both lanes disabled: nothing written, nothing counted.
    do_write(18'h00005, 16'h0000, 1'b1, 1'b1, 1);
    do_read(18'h00005, 1'b0, 1'b0, "no_lane_wr");

    // Address change while waiting restarts latency.
    do_write(18'h00020, 16'h5A5A, 1'b0, 1'b0, 1);
    @(negedge clk);
    set_read(18'h00005, 1'b0, 1'b0);
    @(negedge clk);
    bus.SRAM_ADDR = 18'h00020;
    read_tail(18'h00020, 1'b0, 1'b0, "addr_chg");

    // Read already requested on the write commit edge.
    @(negedge clk);
    set_write(18'h00030, 16'hC3A5, 1'b0, 1'b0);
    @(negedge clk);
    model_write(18'h00030, 16'hC3A5, 1'b0, 1'b0);
    tb_dq_en      = 1'b0;
    bus.SRAM_WE_N = 1'b1;
    bus.SRAM_OE_N = 1'b0;
    read_tail(18'h00030, 1'b0, 1'b0, "commit_to_rd");

    // Contention: WE_N and OE_N both low. Responder must not drive; upper lane
    // captures the pulled-up bus.
    do_write(18'h00040, 16'h1234, 1'b0, 1'b0, 1);
    @(negedge clk);
    bus.SRAM_ADDR = 18'h00040;
    bus.SRAM_UB_N = 1'b0;
    bus.SRAM_LB_N = 1'b1;
    bus.SRAM_CE_N = 1'b0;
    bus.SRAM_WE_N = 1'b0;
    bus.SRAM_OE_N = 1'b0;
    @(negedge clk);
    check("contend_dq", sram_dq, 16'hFFFF);
    check("contend_err", 16'(proto_err), 16'd1);
    bus.SRAM_CE_N = 1'b1;
    bus.SRAM_WE_N = 1'b1;
    bus.SRAM_OE_N = 1'b1;
    model_write(18'h00040, 16'hFFFF, 1'b0, 1'b1);
    do_read(18'h00040, 1'b0, 1'b0, "contend_rd");
    check("err_sticky", 16'(proto_err), 16'd1);

    // Aliasing: upper address bits are ignored.
    do_write(18'h00400, 16'h7E81, 1'b0, 1'b0, 1);
    do_read(18'h00000, 1'b0, 1'b0, "alias");

    // Randomized traffic over a small address pool with random alias bits.
    for (int i = 0; i < 8; i++) begin
      pool[i] = {8'h00, 10'($urandom_range(0, DEPTH - 1))};
      do_write(pool[i], 16'($urandom), 1'b0, 1'b0, 1);
    end
    for (int i = 0; i < 60; i++) begin
      a = {8'($urandom), pool[$urandom_range(0, 7)][ADDR_BITS-1:0]};
      if ($urandom_range(0, 1) == 0) begin
        d = 16'($urandom);
        do_write(a, d, 1'($urandom), 1'($urandom), $urandom_range(1, 3));
      end else begin
        do_read(a, 1'($urandom), 1'($urandom), "rand");
      end
    end

    // Saturation: preload the read counter near its ceiling.
    @(negedge clk);
    force dut.rd_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.rd_count_q;
    exp_rd = 16'hFFFE;
    do_read(18'h00005, 1'b0, 1'b0, "sat_a");
    do_read(18'h00005, 1'b0, 1'b0, "sat_b");

    // Reset while driving: bus released at once, counters and flag cleared.
    @(negedge clk);
    set_read(18'h00005, 1'b0, 1'b0);
    repeat (READ_LATENCY + 1) @(negedge clk);
    check("rst_rd_drive", sram_dq, model_read(18'h00005, 1'b0, 1'b0));
    #2;
    rst = 1'b0;
    #1;
    check("rst_rd_dq", sram_dq, 16'hFFFF);
    check("rst_rd_cnt", rd_count, 16'd0);
    check("rst_err_clr", 16'(proto_err), 16'd0);
    idle_pins();
    exp_rd = 16'd0;
    exp_wr = 16'd0;
    @(negedge clk);
    rst = 1'b1;

    // Reset during a pending write: write discarded.
    @(negedge clk);
    set_write(18'h00005, 16'h1111, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("wr_pend_busy", 16'(busy), 16'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_wr_busy", 16'(busy), 16'd0);
    idle_pins();
    @(negedge clk);
    rst = 1'b1;
    do_read(18'h00005, 1'b0, 1'b0, "rst_wr_rd");
    check("rst_wr_count", wr_count, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
Clocked responder for the external 16-bit asynchronous-SRAM pin interface (SRAM_DQ/ADDR/UB_N/LB_N/WE_N/CE_N/OE_N) that the memory stage's SRAM controller initiates on. It behaves as the SRAM device: it holds a byte-lane memory array, answers reads after a programmable latency, and commits writes on WE_N/CE_N release. It replaces the physical chip in simulation and in on-chip bring-up builds, and exposes access counters and a sticky protocol-error flag for debug.

Parameters:
ADDR_BITS, 10, address bits actually decoded; SRAM_ADDR[ADDR_BITS-1:0] indexes the array, upper bits are ignored, so addresses alias/wrap.
READ_LATENCY, 2, clock edges from a sampled read request to data driven on SRAM_DQ; legal range 1..15.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
SRAM_DQ  inout  16  data bus; driven only in RD_DRIVE, otherwise hi-z
SRAM_ADDR  in  18  word address
SRAM_UB_N  in  1  upper byte [15:8] enable, active-low
SRAM_LB_N  in  1  lower byte [7:0] enable, active-low
SRAM_WE_N  in  1  write enable, active-low
SRAM_CE_N  in  1  chip enable, active-low
SRAM_OE_N  in  1  output enable, active-low
rd_count  out  16  completed reads, saturating
wr_count  out  16  committed writes, saturating
proto_err  out  1  sticky: WE_N=0 and OE_N=0 were sampled while CE_N=0
busy  out  1  high in RD_WAIT or WR_PEND

Behaviour:
- Reset (rst=0, async): state=IDLE, rd_count=0, wr_count=0, proto_err=0, busy=0, SRAM_DQ hi-z. Array contents are not cleared.
- Pins are sampled on the rising edge of clk. The responder does not synchronize them: the initiator runs on the same clock.
- Request decode, evaluated per edge:
  - rd_req = !CE_N & !OE_N & WE_N.
  - wr_act = !CE_N & !WE_N. WE_N low dominates OE_N.
- FSM:
  - IDLE: on wr_act, go to WR_PEND and latch addr, DQ and byte enables. Else on rd_req, go to RD_WAIT with cnt=READ_LATENCY-1 and latch addr.
  - RD_WAIT: request dropped -> IDLE. SRAM_ADDR differs from the latched addr -> relatch and reload cnt. cnt==0 -> RD_DRIVE and rd_count+1. Else cnt-1.
  - RD_DRIVE: the drive enable is combinational, drive_en = (state==RD_DRIVE) & rd_req. Bus release therefore happens in the same cycle OE_N/CE_N rise or WE_N falls, with no contention.
  - RD_DRIVE data: for each lane, drive mem[addr] if that lane's enable is low, else hi-z.
  - RD_DRIVE exits: address change -> RD_WAIT with reload and no count. Request drop -> IDLE. wr_act -> WR_PEND.
  - WR_PEND: relatch addr, DQ and lanes on every edge while wr_act holds. On the first edge with wr_act=0, write the latched lanes to mem[addr], wr_count+1, and go to IDLE.
  - WR_PEND commit exceptions: both lanes disabled -> no write, no count. If rd_req is already asserted on the commit edge, go to RD_WAIT instead of IDLE.
- Latency: with the request and address first sampled at edge k, data is valid on SRAM_DQ after edge k+READ_LATENCY.
- Read-after-write to the same address returns the new data, because the write commits before RD_WAIT completes.
- proto_err sets on any edge where !CE_N & !WE_N & !OE_N, and clears only on reset.
- Counters saturate at 16'hFFFF and do not wrap.
- Reset asserted mid-read or mid-write: the in-flight write is discarded and the bus is released asynchronously.

Decomposition:
- Shared package holds the pin-interface constants: SRAM_ADDR_W=18, SRAM_DATA_W=16, BYTE_W=8, and the state encoding (IDLE, RD_WAIT, RD_DRIVE, WR_PEND).
- One sub-module, sram_byte_array: 2^ADDR_BITS x 16 storage with two per-byte write enables and one asynchronous read port, no reset. The FSM, counters and tri-state logic stay in sram_responder.

Test Plan:
- Write then read: write addr 0x005 data 0xBEEF with UB_N=LB_N=0 and WE_N low for 2 cycles, then CE_N/OE_N low with READ_LATENCY=2 -> SRAM_DQ=0xBEEF two edges after the request; wr_count=1, rd_count=1.
- Byte lanes: write 0x1234 to 0x00A, then write 0xAB00 with LB_N=1 -> read returns 0xAB34. Read with UB_N=1 -> DQ[15:8] hi-z, DQ[7:0]=0x34.
- Address change mid-read: change addr during RD_WAIT -> latency restarts and the new address's data is returned. rd_count increments once per completed read only.
- Contention and error: drive OE_N=0 and WE_N=0 with CE_N=0 -> SRAM_DQ stays hi-z, a write is performed, proto_err=1. proto_err remains set until rst=0.
- Aliasing and saturation: with ADDR_BITS=10, write to 0x00400 -> readable at 0x00000. Force 65536 reads -> rd_count holds 16'hFFFF.
- Reset mid-operation: assert rst during WR_PEND -> no array update, wr_count=0, DQ hi-z immediately.
